// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle controller: state encoding, ALU codes,
// condition codes and datapath mux select constants.
package mc_ctrl_fsm_pkg;

  localparam int unsigned FLAG_W    = 4;
  localparam int unsigned CMD_W     = 4;
  localparam int unsigned RETIRED_W = 32;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  localparam state_e RST_STATE = S_FETCH;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctl_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [CMD_W-1:0] CMD_ADD = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AND = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_ORR = 4'b1100;
  localparam logic [CMD_W-1:0] CMD_CMP = 4'b1010;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic       ADR_PC      = 1'b0;
  localparam logic       ADR_RESULT  = 1'b1;
  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // CMP executes as a subtract; unknown commands fall back to ADD
  function automatic alu_ctl_e cmd_to_alu(input logic [CMD_W-1:0] cmd);
    case (cmd)
      CMD_SUB, CMD_CMP: return ALU_SUB;
      CMD_AND:          return ALU_AND;
      CMD_ORR:          return ALU_ORR;
      default:          return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Instruction-field / control-strobe bundle between the multicycle datapath
// (master) and its main controller (slave).
interface mc_ctrl_fsm_if;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic       mem_ready;

  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [1:0] alu_control;
  logic [3:0] flags;
  logic       busy;

  modport master (
    output op, funct, rd, cond, alu_flags, mem_ready,
    input  ir_write, pc_write, reg_write, mem_write, adr_src, alu_src_a, alu_src_b,
           result_src, imm_src, alu_control, flags, busy
  );

  modport slave (
    input  op, funct, rd, cond, alu_flags, mem_ready,
    output ir_write, pc_write, reg_write, mem_write, adr_src, alu_src_a, alu_src_b,
           result_src, imm_src, alu_control, flags, busy
  );

endinterface

// File: rtl/mc_cond_eval.sv
// Condition-code evaluator: decides whether an instruction executes given NZCV.
module mc_cond_eval
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [3:0]        cond_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic              cond_ex_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  // Code 1111 falls to the default and squashes the instruction
  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU main controller: sequences fetch/decode/memory/execute phases,
// holds NZCV and gates writes by the condition field. MC_PERF_CNT_EN adds 'retired'.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
`ifdef MC_PERF_CNT_EN
  output logic [RETIRED_W-1:0] retired,
`endif
  mc_ctrl_fsm_if.slave         bus
);

  state_e            state_q, state_d, dec_state;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              cond_q, cond_d;
  logic              cond_ex;
  logic [CMD_W-1:0]  cmd;
  logic              is_cmp, rd_pc, in_exec;
  alu_ctl_e          exec_alu;

  assign cmd      = bus.funct[4:1];
  assign is_cmp   = (cmd == CMD_CMP);
  assign rd_pc    = (bus.rd == 4'd15);
  assign exec_alu = cmd_to_alu(cmd);
  assign in_exec  = (state_q == S_EXECR) || (state_q == S_EXECI);
  assign bus.flags = flags_q;

  mc_cond_eval u_cond_eval (
    .cond_i    (bus.cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= RST_STATE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      cond_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cond_q  <= cond_d;
    end
  end

  // C and V only carry meaning for arithmetic ops; logical ops keep them
  always_comb begin
    flags_d = flags_q;
    cond_d  = cond_q;
    if (state_q == S_DECODE) cond_d = cond_ex;
    if (in_exec && (bus.funct[0] || is_cmp) && cond_q) begin
      flags_d[3:2] = bus.alu_flags[3:2];
      if (exec_alu == ALU_ADD || exec_alu == ALU_SUB) flags_d[1:0] = bus.alu_flags[1:0];
    end
  end

  always_comb begin
    dec_state       = reset ? S_FETCH : state_q;
    state_d         = state_q;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.mem_write   = 1'b0;
    bus.adr_src     = ADR_PC;
    bus.alu_src_a   = SRCA_REG;
    bus.alu_src_b   = SRCB_REG;
    bus.result_src  = RES_ALUOUT;
    bus.alu_control = ALU_ADD;
    bus.imm_src     = bus.op;
    bus.busy        = (dec_state != S_FETCH);
    case (dec_state)
      S_FETCH: begin
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_FOUR;
        bus.result_src = RES_ALU;
        bus.ir_write   = bus.mem_ready;
        bus.pc_write   = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_FOUR;
        bus.result_src = RES_ALU;
        case (bus.op)
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          OP_DP:   state_d = bus.funct[5] ? S_EXECI : S_EXECR;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_b = SRCB_IMM;
        state_d       = bus.funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.adr_src = ADR_RESULT;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        bus.adr_src   = ADR_RESULT;
        bus.mem_write = cond_q;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_MEMWB, S_ALUWB: begin
        bus.result_src = (dec_state == S_MEMWB) ? RES_DATA : RES_ALUOUT;
        bus.pc_write   = rd_pc & cond_q;
        bus.reg_write  = ~rd_pc & cond_q;
        state_d        = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        bus.alu_src_b   = (dec_state == S_EXECI) ? SRCB_IMM : SRCB_REG;
        bus.alu_control = exec_alu;
        state_d         = is_cmp ? S_FETCH : S_ALUWB;
      end
      S_BRANCH: begin
        bus.alu_src_a  = SRCA_ALUOUT;
        bus.alu_src_b  = SRCB_IMM;
        bus.result_src = RES_ALU;
        bus.pc_write   = cond_q;
        state_d        = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // An abandoned instruction must not leave a strobe behind in the reset cycle
    if (reset) begin
      bus.ir_write  = 1'b0;
      bus.pc_write  = 1'b0;
      bus.reg_write = 1'b0;
      bus.mem_write = 1'b0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [RETIRED_W-1:0] retired_q;

  // cond_q still holds the previous instruction's outcome when FETCH completes
  always_ff @(posedge clk) begin
    if (reset) retired_q <= '0;
    else if (state_q == S_FETCH && bus.mem_ready && cond_q) retired_q <= retired_q + RETIRED_W'(1);
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed vector table, random instruction stream against
// a transaction-level model, and a mid-instruction reset sequence.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_ctrl_fsm_if bus ();
`ifdef MC_PERF_CNT_EN
  logic [31:0] retired;
`endif

  mc_ctrl_fsm dut (
    .clk   (clk),
    .reset (reset),
`ifdef MC_PERF_CNT_EN
    .retired (retired),
`endif
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cond;
    logic [3:0] af;
    int         sf;
    int         sm;
    int         cyc;
    int         regw;
    int         pcw;
    int         memw;
    logic [3:0] fl;
    logic [1:0] alu;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic [3:0]  flags_m;
  logic        last_cond_m;
  logic [31:0] retired_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Condition pairs: even code tests a predicate, odd code is its inverse
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic base;
    case (c[3:1])
      3'd0:    base = f[2];
      3'd1:    base = f[1];
      3'd2:    base = f[3];
      3'd3:    base = f[0];
      3'd4:    base = f[1] && !f[2];
      3'd5:    base = (f[3] == f[0]);
      3'd6:    base = !f[2] && (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic model(input vec_t vin, output vec_t vout);
    logic       ce, upd;
    logic [3:0] cmd;
    vout = vin;
    ce   = cond_model(vin.cond, flags_m);
    retired_m   = retired_m + 32'(last_cond_m);
    last_cond_m = ce;
    cmd  = vin.funct[4:1];
    upd  = 1'b0;
    vout.regw = 0; vout.pcw = 1; vout.memw = 0; vout.alu = 2'd0;
    case (vin.op)
      2'b00: begin
        if (cmd == 4'b0010 || cmd == 4'b1010) vout.alu = 2'd1;
        else if (cmd == 4'b0000) vout.alu = 2'd2;
        else if (cmd == 4'b1100) vout.alu = 2'd3;
        if (cmd == 4'b1010) begin
          vout.cyc = 3 + vin.sf;
          upd = ce;
        end else begin
          vout.cyc = 4 + vin.sf;
          upd = ce && vin.funct[0];
          if (vin.rd == 4'd15) vout.pcw = vout.pcw + int'(ce);
          else vout.regw = int'(ce);
        end
        if (upd) begin
          flags_m[3:2] = vin.af[3:2];
          if (vout.alu <= 2'd1) flags_m[1:0] = vin.af[1:0];
        end
      end
      2'b01: begin
        if (vin.funct[0]) begin
          vout.cyc = 5 + vin.sf + vin.sm;
          if (vin.rd == 4'd15) vout.pcw = vout.pcw + int'(ce);
          else vout.regw = int'(ce);
        end else begin
          vout.cyc  = 4 + vin.sf + vin.sm;
          vout.memw = ce ? vin.sm + 1 : 0;
        end
      end
      2'b10: begin
        vout.cyc = 3 + vin.sf;
        vout.pcw = vout.pcw + int'(ce);
      end
      default: vout.cyc = 2 + vin.sf;
    endcase
    vout.fl = flags_m;
  endtask

  // Runs one instruction from a FETCH cycle until the next FETCH cycle
  task automatic run_instr(input string tag, input vec_t v);
    int         cyc, nreg, npc, nmem, nir, fs, ms;
    logic       fetched, done;
    logic [1:0] alu_seen;
    cyc = 0; nreg = 0; npc = 0; nmem = 0; nir = 0; fs = 0; ms = 0;
    fetched = 1'b0; done = 1'b0; alu_seen = 2'bxx;
    bus.op = v.op; bus.funct = v.funct; bus.rd = v.rd; bus.cond = v.cond; bus.alu_flags = v.af;
    while (!done) begin
      if (!bus.busy) begin
        if (!fetched && fs < v.sf) begin bus.mem_ready = 1'b0; fs++; end
        else bus.mem_ready = 1'b1;
      end else if (bus.adr_src) begin
        if (ms < v.sm) begin bus.mem_ready = 1'b0; ms++; end
        else bus.mem_ready = 1'b1;
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (fetched && !bus.busy) begin
        done = 1'b1;
      end else begin
        nir  += int'(bus.ir_write);
        npc  += int'(bus.pc_write);
        nreg += int'(bus.reg_write);
        nmem += int'(bus.mem_write);
        if (bus.ir_write) fetched = 1'b1;
        if (cyc == v.sf + 2) alu_seen = bus.alu_control;
        cyc++;
        if (cyc > 40) begin
          checks++;
          failures++;
          $display("FAIL %s.timeout actual=%0d required=%0d", tag, cyc, v.cyc);
          return;
        end
        @(posedge clk);
        @(negedge clk);
      end
    end
    check({tag, ".cycles"}, 32'(cyc), 32'(v.cyc));
    check({tag, ".ir_write"}, 32'(nir), 32'd1);
    check({tag, ".reg_write"}, 32'(nreg), 32'(v.regw));
    check({tag, ".pc_write"}, 32'(npc), 32'(v.pcw));
    check({tag, ".mem_write"}, 32'(nmem), 32'(v.memw));
    check({tag, ".flags"}, 32'(bus.flags), 32'(v.fl));
    if (v.op == 2'b00) check({tag, ".alu_control"}, 32'(alu_seen), 32'(v.alu));
`ifdef MC_PERF_CNT_EN
    check({tag, ".retired"}, retired, retired_m);
`endif
  endtask

  vec_t vecs[$];

  initial begin
    vec_t       v, m;
    logic [17:0] snap;

    vecs.push_back('{2'b00, 6'b001000, 4'd1,  4'b1110, 4'b1111, 0, 0, 4,  1, 1, 0, 4'b0000, 2'd0});
    vecs.push_back('{2'b00, 6'b000101, 4'd0,  4'b1110, 4'b0110, 0, 0, 4,  1, 1, 0, 4'b0110, 2'd1});
    vecs.push_back('{2'b10, 6'b000000, 4'd0,  4'b0000, 4'b0000, 0, 0, 3,  0, 2, 0, 4'b0110, 2'd0});
    vecs.push_back('{2'b10, 6'b000000, 4'd0,  4'b0001, 4'b0000, 0, 0, 3,  0, 1, 0, 4'b0110, 2'd0});
    vecs.push_back('{2'b00, 6'b000001, 4'd2,  4'b1110, 4'b1000, 0, 0, 4,  1, 1, 0, 4'b1010, 2'd2});
    vecs.push_back('{2'b01, 6'b011001, 4'd3,  4'b1110, 4'b0000, 2, 3, 10, 1, 1, 0, 4'b1010, 2'd0});
    vecs.push_back('{2'b00, 6'b010100, 4'd0,  4'b1110, 4'b0110, 0, 0, 3,  0, 1, 0, 4'b0110, 2'd1});
    vecs.push_back('{2'b01, 6'b011000, 4'd4,  4'b0001, 4'b0000, 0, 1, 5,  0, 1, 0, 4'b0110, 2'd0});
    vecs.push_back('{2'b01, 6'b011000, 4'd4,  4'b1110, 4'b0000, 0, 2, 6,  0, 1, 3, 4'b0110, 2'd0});
    vecs.push_back('{2'b00, 6'b111000, 4'd15, 4'b1110, 4'b1111, 0, 0, 4,  0, 2, 0, 4'b0110, 2'd3});
    vecs.push_back('{2'b00, 6'b001001, 4'd5,  4'b1111, 4'b1001, 0, 0, 4,  0, 1, 0, 4'b0110, 2'd0});
    vecs.push_back('{2'b11, 6'b000000, 4'd0,  4'b1110, 4'b0000, 1, 0, 3,  0, 1, 0, 4'b0110, 2'd0});
    vecs.push_back('{2'b00, 6'b001001, 4'd5,  4'b1010, 4'b1001, 0, 0, 4,  1, 1, 0, 4'b1001, 2'd0});
    vecs.push_back('{2'b00, 6'b100001, 4'd6,  4'b1011, 4'b0110, 0, 0, 4,  0, 1, 0, 4'b1001, 2'd2});
    vecs.push_back('{2'b01, 6'b011001, 4'd15, 4'b1110, 4'b0000, 0, 0, 5,  0, 2, 0, 4'b1001, 2'd0});
    vecs.push_back('{2'b00, 6'b011001, 4'd7,  4'b1110, 4'b0110, 0, 0, 4,  1, 1, 0, 4'b0101, 2'd3});
    vecs.push_back('{2'b00, 6'b000011, 4'd8,  4'b1110, 4'b1011, 1, 0, 5,  1, 1, 0, 4'b1011, 2'd0});

    flags_m = 4'b0000; last_cond_m = 1'b0; retired_m = 32'd0;
    reset = 1'b1;
    bus.op = 2'b00; bus.funct = 6'd0; bus.rd = 4'd0; bus.cond = 4'b1110;
    bus.alu_flags = 4'd0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_strobes", 32'({bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.busy}), 32'd0);
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    snap = {bus.busy, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.adr_src,
            bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_control, bus.flags};
    check("reset_fetch_decode", 32'(snap), 32'({6'b000000, 2'b01, 2'b10, 2'b10, 2'b00, 4'b0000}));
`ifdef MC_PERF_CNT_EN
    check("reset_retired", retired, 32'd0);
`endif

    foreach (vecs[i]) begin
      model(vecs[i], m);
      run_instr($sformatf("vec%0d", i), vecs[i]);
    end

    for (int i = 0; i < 150; i++) begin
      v.op    = 2'($urandom_range(0, 3));
      v.funct = 6'($urandom);
      v.rd    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      v.cond  = 4'($urandom);
      v.af    = 4'($urandom);
      v.sf    = $urandom_range(0, 2);
      v.sm    = $urandom_range(0, 2);
      model(v, m);
      run_instr($sformatf("rnd%0d", i), m);
    end

    // Leave nonzero flags behind, then abandon a stalled store with reset
    v = '{2'b00, 6'b000101, 4'd1, 4'b1110, 4'b1001, 0, 0, 0, 0, 0, 0, 4'b0000, 2'd0};
    model(v, m);
    run_instr("pre_reset_subs", m);
    bus.op = 2'b01; bus.funct = 6'b011000; bus.rd = 4'd2; bus.cond = 4'b1110;
    bus.mem_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    #1;
    check("memwr_stall_mem_write", 32'(bus.mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_cycle_mem_write", 32'(bus.mem_write), 32'd0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_busy", 32'(bus.busy), 32'd0);
    check("post_reset_flags", 32'(bus.flags), 32'd0);
`ifdef MC_PERF_CNT_EN
    check("post_reset_retired", retired, 32'd0);
`endif
    flags_m = 4'b0000; last_cond_m = 1'b0; retired_m = 32'd0;
    v = '{2'b00, 6'b001000, 4'd1, 4'b1110, 4'b1111, 0, 0, 0, 0, 0, 0, 4'b0000, 2'd0};
    model(v, m);
    run_instr("after_reset_add", m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
